// File: rtl/prio_pkg.sv
// Shared types and constants for the 8-way grant decoder: index/grant widths,
// hold-counter width, FSM state encoding and the index-to-one-hot helper.
package prio_pkg;

  localparam int N_REQ  = 8;
  localparam int IDX_W  = 3;
  localparam int HOLD_W = 8;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [N_REQ-1:0]  grant_t;
  typedef logic [HOLD_W-1:0] hold_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic grant_t idx_to_onehot(input idx_t idx);
    grant_t g;
    g      = '0;
    g[idx] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/prio_decod_8b_if.sv
// Index-in / grant-out bundle between the request encoder, the decoder and
// the eight request owners.
interface prio_decod_8b_if;
  import prio_pkg::*;

  idx_t   in_idx;
  logic   in_valid;
  logic   in_ready;
  grant_t onehot;
  logic   out_valid;
  logic   out_ack;
  logic   timeout;
  logic   busy;

  modport master (
    output in_idx, in_valid, out_ack,
    input  in_ready, onehot, out_valid, timeout, busy
  );

  modport slave (
    input  in_idx, in_valid, out_ack,
    output in_ready, onehot, out_valid, timeout, busy
  );

endinterface

// File: rtl/prio_fifo2.sv
// Two-entry index FIFO with 1-bit wrapping pointers and an explicit occupancy
// count; push is ignored when full and pop is ignored when empty.
module prio_fifo2
  import prio_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  idx_t din,
  output idx_t dout,
  output logic full,
  output logic empty
);

  idx_t       mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage is deliberately left unreset; count gates every read, so
  // stale contents are never observed and reset stays off the data path.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    count <= 2'd2);

endmodule

// File: rtl/prio_decod_8b.sv
// Sequential 3-to-8 grant decoder: buffers encoder indices in a 2-deep FIFO and
// replays each as a held one-hot grant, released by ack or a hold timeout.
module prio_decod_8b
  import prio_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16
) (
  input logic            clk,
  input logic            rst_n,
  prio_decod_8b_if.slave bus
);

  localparam bit    TO_EN = (HOLD_MAX != 0);
  localparam hold_t TERM  = (HOLD_MAX == 0) ? hold_t'(0) : hold_t'(HOLD_MAX - 1);

  state_t state_q, state_d;
  hold_t  hold_q,  hold_d;
  grant_t onehot_q, onehot_d;

  idx_t   head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;
  logic   terminal;

  prio_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.in_valid),
    .pop   (pop),
    .din   (bus.in_idx),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign terminal = TO_EN && (hold_q == TERM);

  // NOTE: every always_comb output gets a default first so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    onehot_d = onehot_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        onehot_d = '0;
        if (!fifo_empty) begin
          pop      = 1'b1;
          onehot_d = idx_to_onehot(head);
          hold_d   = '0;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (hold_q != '1) hold_d = hold_q + hold_t'(1);
        if (bus.out_ack || terminal) begin
          onehot_d = '0;
          state_d  = GAP;
        end
      end
      GAP: begin
        onehot_d = '0;
        state_d  = IDLE;
      end
      default: begin
        onehot_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      onehot_q <= onehot_d;
    end
  end

  // Timeout is gated by ack so an ack in the terminal cycle wins over the drop.
  assign bus.timeout   = (state_q == DRIVE) && terminal && !bus.out_ack;
  assign bus.onehot    = onehot_q;
  assign bus.out_valid = (state_q == DRIVE);
  assign bus.in_ready  = !fifo_full;
  assign bus.busy      = !fifo_empty || (state_q != IDLE);

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    bus.out_valid |-> $onehot(bus.onehot));
  a_grant_zero:   assert property (@(posedge clk) disable iff (!rst_n)
    !bus.out_valid |-> (bus.onehot == '0));
  a_timeout_drv:  assert property (@(posedge clk) disable iff (!rst_n)
    bus.timeout |-> bus.out_valid);

endmodule

// File: tb/tb_prio_decod_8b.sv
// Bench for prio_decod_8b: directed pushes/acks with a grant scoreboard checked
// by an independent monitor, plus direct checks of latency, backpressure and reset.
module tb_prio_decod_8b;
  import prio_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prio_decod_8b_if bus4();
  prio_decod_8b_if bus0();

  prio_decod_8b #(.HOLD_MAX(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  prio_decod_8b #(.HOLD_MAX(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  typedef struct {
    grant_t oh;
    int     len;
    bit     to;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input idx_t idx);
    int budget;
    budget        = 50;
    bus4.in_idx   = idx;
    bus4.in_valid = 1'b1;
    while (!bus4.in_ready && budget > 0) begin
      tick();
      budget--;
    end
    check("push_accepted", 32'(bus4.in_ready), 32'd1);
    tick();
    bus4.in_valid = 1'b0;
  endtask

  // Acks the current (or next) grant during its k-th DRIVE cycle.
  task automatic ack4(input int k);
    int budget;
    budget = 50;
    while (!bus4.out_valid && budget > 0) begin
      tick();
      budget--;
    end
    check("grant_seen", 32'(bus4.out_valid), 32'd1);
    repeat (k - 1) tick();
    bus4.out_ack = 1'b1;
    tick();
    bus4.out_ack = 1'b0;
  endtask

  task automatic wait_idle4();
    int budget;
    budget = 50;
    while ((bus4.busy || bus4.out_valid) && budget > 0) begin
      tick();
      budget--;
    end
    check("idle_reached", 32'(bus4.busy), 32'd0);
  endtask

  // Monitor: measures each grant of dut4 and compares it with the scoreboard.
  bit     in_grant = 1'b0;
  grant_t cur_oh;
  int     g_len, to_cnt;
  int     low_len = 100;
  logic   to_last;
  exp_t   e;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_grant = 1'b0;
      g_len    = 0;
      to_cnt   = 0;
      low_len  = 100;
    end else if (bus4.out_valid) begin
      if (!in_grant) begin
        check("gap_before_grant", 32'(low_len >= 2), 32'd1);
        in_grant = 1'b1;
        cur_oh   = bus4.onehot;
        g_len    = 0;
        to_cnt   = 0;
      end else begin
        check("onehot_stable", 32'(bus4.onehot), 32'(cur_oh));
      end
      g_len++;
      to_last = bus4.timeout;
      if (bus4.timeout) to_cnt++;
      low_len = 0;
    end else begin
      check("idle_timeout_low", 32'(bus4.timeout), 32'd0);
      check("idle_onehot_zero", 32'(bus4.onehot), 32'd0);
      if (in_grant) begin
        in_grant = 1'b0;
        check("grant_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("grant_onehot", 32'(cur_oh), 32'(e.oh));
          check("grant_length", 32'(g_len), 32'(e.len));
          check("timeout_count", 32'(to_cnt), e.to ? 32'd1 : 32'd0);
          check("timeout_last", 32'(to_last), 32'(e.to));
        end
      end
      low_len++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bool_init();
    repeat (3) @(posedge clk);
    #1;
    check("rst_onehot",    32'(bus4.onehot),    32'h00);
    check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    check("rst_timeout",   32'(bus4.timeout),   32'd0);
    check("rst_busy",      32'(bus4.busy),      32'd0);
    check("rst_in_ready",  32'(bus4.in_ready),  32'd1);
    rst_n = 1'b1;
    tick();

    // Single push of 5: visible two cycles after the handshake, acked on cycle 3.
    sb.push_back('{oh: 8'h20, len: 3, to: 1'b0});
    push4(3'd5);
    check("latency_n1_no_grant", 32'(bus4.out_valid), 32'd0);
    check("busy_after_push",     32'(bus4.busy),      32'd1);
    tick();
    check("latency_n2_valid",  32'(bus4.out_valid), 32'd1);
    check("latency_n2_onehot", 32'(bus4.onehot),    32'h20);
    ack4(3);
    check("gap_onehot",    32'(bus4.onehot),    32'h00);
    check("gap_out_valid", 32'(bus4.out_valid), 32'd0);
    tick();
    check("idle_not_busy", 32'(bus4.busy), 32'd0);
    wait_idle4();

    // Back-to-back 3,3,7: first 3 pops as the second is pushed, so 7 fills the FIFO.
    sb.push_back('{oh: 8'h08, len: 2, to: 1'b0});
    sb.push_back('{oh: 8'h08, len: 2, to: 1'b0});
    sb.push_back('{oh: 8'h80, len: 1, to: 1'b0});
    sb.push_back('{oh: 8'h04, len: 4, to: 1'b0});
    push4(3'd3);
    push4(3'd3);
    push4(3'd7);
    check("in_ready_full", 32'(bus4.in_ready), 32'd0);
    fork
      push4(3'd2);
      begin
        ack4(1);
        ack4(2);
        ack4(1);
        ack4(4);
      end
    join
    wait_idle4();

    // HOLD_MAX=4 timeout: visible exactly 4 cycles, pulse on the 4th.
    sb.push_back('{oh: 8'h01, len: 4, to: 1'b1});
    push4(3'd0);
    tick();
    check("to_grant_onehot", 32'(bus4.onehot), 32'h01);
    repeat (3) tick();
    check("to_pulse",        32'(bus4.timeout), 32'd1);
    check("to_still_valid",  32'(bus4.out_valid), 32'd1);
    tick();
    check("to_dropped",      32'(bus4.onehot),  32'h00);
    check("to_pulse_ended",  32'(bus4.timeout), 32'd0);
    wait_idle4();

    // Reset mid-grant with two indices queued.
    push4(3'd1);
    push4(3'd2);
    push4(3'd6);
    check("pre_rst_valid", 32'(bus4.out_valid), 32'd1);
    check("pre_rst_full",  32'(bus4.in_ready),  32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_onehot",    32'(bus4.onehot),    32'h00);
    check("mid_rst_out_valid", 32'(bus4.out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(bus4.in_ready),  32'd1);
    check("mid_rst_busy",      32'(bus4.busy),      32'd0);
    check("mid_rst_timeout",   32'(bus4.timeout),   32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_rst_no_grant", 32'(bus4.out_valid), 32'd0);
    end
    check("post_rst_not_busy", 32'(bus4.busy), 32'd0);

    // HOLD_MAX=0: grant held past counter saturation, no timeout, ack releases.
    begin
      bit held;
      bit to_seen;
      held          = 1'b1;
      to_seen       = 1'b0;
      bus0.in_idx   = 3'd2;
      bus0.in_valid = 1'b1;
      tick();
      bus0.in_valid = 1'b0;
      tick();
      check("h0_grant_valid",  32'(bus0.out_valid), 32'd1);
      check("h0_grant_onehot", 32'(bus0.onehot),    32'h04);
      for (int i = 0; i < 300; i++) begin
        tick();
        if (!bus0.out_valid || bus0.onehot != 8'h04) held = 1'b0;
        if (bus0.timeout) to_seen = 1'b1;
      end
      check("h0_held_300",    32'(held),    32'd1);
      check("h0_no_timeout",  32'(to_seen), 32'd0);
      bus0.out_ack = 1'b1;
      tick();
      bus0.out_ack = 1'b0;
      check("h0_released_valid",  32'(bus0.out_valid), 32'd0);
      check("h0_released_onehot", 32'(bus0.onehot),    32'h00);
      check("h0_release_timeout", 32'(bus0.timeout),   32'd0);
      tick();
      tick();
      check("h0_idle", 32'(bus0.busy), 32'd0);
    end

    repeat (3) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic bool_init();
    bus4.in_idx   = '0;
    bus4.in_valid = 1'b0;
    bus4.out_ack  = 1'b0;
    bus0.in_idx   = '0;
    bus0.in_valid = 1'b0;
    bus0.out_ack  = 1'b0;
  endtask

endmodule
